prf_free_list: RTL and testbench

- Manages the physical-register tags that are not in the architectural map. It hands out up to two tags per cycle to rename and takes back up to two old tags (Told) per cycle at retire.
- Implemented as a circular buffer with three pointers:
  - spec head: next tag to allocate.
  - arch head: allocation point as of the last retired instruction.
  - tail: next slot for a freed tag.
- On a retire-time flush the spec head snaps back to the arch head, which reclaims every squashed allocation in one cycle.
- Sits between the rename map table and the retire stage that feeds the architectural map and physical register file.

---
 rtl/prf_free_list_pkg.sv | 14 +
 rtl/prf_free_list_if.sv | 25 ++
 rtl/prf_free_list_fl_ptr_inc.sv | 12 +
 rtl/prf_free_list.sv | 88 ++++++++
 tb/tb_prf_free_list.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/prf_free_list_pkg.sv
// prf_free_list_pkg: sizing, tag/count/pointer types and the zero-register tag shared by the free list.
package prf_free_list_pkg;
    localparam int N_ENTRY_ROB = 32;
    localparam int N_PRF = N_ENTRY_ROB + 33;
    localparam int N_ARCH = 32;
    localparam int TAG_W = $clog2(N_PRF);
    localparam int DEPTH = N_PRF - N_ARCH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;
    localparam tag_t ZERO_REG = '0;
endpackage

// File: rtl/prf_free_list_if.sv
// prf_free_list_if: rename allocation, retire free and flush signals of the free list.
interface prf_free_list_if;
    import prf_free_list_pkg::*;
    logic alloc_req_0;
    logic alloc_req_1;
    logic alloc_gnt_0;
    logic alloc_gnt_1;
    tag_t alloc_tag_0;
    tag_t alloc_tag_1;
    logic retire_valid_0;
    logic retire_valid_1;
    tag_t free_tag_0;
    tag_t free_tag_1;
    logic flush;
    cnt_t free_count;
    logic free_list_err;
    modport master (
        output alloc_req_0, alloc_req_1, retire_valid_0, retire_valid_1, free_tag_0, free_tag_1, flush,
        input  alloc_gnt_0, alloc_gnt_1, alloc_tag_0, alloc_tag_1, free_count, free_list_err
    );
    modport slave (
        input  alloc_req_0, alloc_req_1, retire_valid_0, retire_valid_1, free_tag_0, free_tag_1, flush,
        output alloc_gnt_0, alloc_gnt_1, alloc_tag_0, alloc_tag_1, free_count, free_list_err
    );
endinterface

// File: rtl/prf_free_list_fl_ptr_inc.sv
// fl_ptr_inc: adds 0/1/2 to a free-list pointer with explicit wrap at DEPTH.
module fl_ptr_inc
    import prf_free_list_pkg::*;
(
    input  ptr_t       i_ptr,
    input  logic [1:0] i_inc,
    output ptr_t       o_ptr
);
    logic [PTR_W:0] w_sum;
    assign w_sum = {1'b0, i_ptr} + {{(PTR_W-1){1'b0}}, i_inc};
    assign o_ptr = (w_sum >= (PTR_W+1)'(DEPTH)) ? ptr_t'(w_sum - (PTR_W+1)'(DEPTH)) : ptr_t'(w_sum);
endmodule

// File: rtl/prf_free_list.sv
// prf_free_list: two-wide circular free list of physical tags with spec head, arch head and tail.
// Defining FREE_LIST_CHECK_EN adds the sticky free_list_err consistency checks.
module prf_free_list
    import prf_free_list_pkg::*;
(
    input logic clk,
    input logic rst_n,
    prf_free_list_if.slave fl_if
);
    tag_t           r_entry [DEPTH];
    ptr_t           r_head;
    ptr_t           r_arch_head;
    ptr_t           r_tail;
    cnt_t           r_count;
    logic           w_gnt_0;
    logic           w_gnt_1;
    logic [1:0]     w_n_gnt;
    logic [1:0]     w_n_free;
    logic [CNT_W:0] w_count_nx;
    ptr_t           w_head_p1;
    ptr_t           w_head_nx;
    ptr_t           w_arch_nx;
    ptr_t           w_tail_p1;
    ptr_t           w_tail_nx;

    // Grants are held low during reset even though the count already reads DEPTH.
    assign w_gnt_0 = rst_n && fl_if.alloc_req_0 && (r_count != '0) && !fl_if.flush;
    assign w_gnt_1 = rst_n && fl_if.alloc_req_1 && (r_count >= (fl_if.alloc_req_0 ? cnt_t'(2) : cnt_t'(1))) && !fl_if.flush;
    assign w_n_gnt = {1'b0, w_gnt_0} + {1'b0, w_gnt_1};
    assign w_n_free = {1'b0, fl_if.retire_valid_0} + {1'b0, fl_if.retire_valid_1};
    assign w_count_nx = {1'b0, r_count} - {{(CNT_W-1){1'b0}}, w_n_gnt} + {{(CNT_W-1){1'b0}}, w_n_free};

    fl_ptr_inc u_head_p1 (.i_ptr(r_head),      .i_inc(2'd1),     .o_ptr(w_head_p1));
    fl_ptr_inc u_head    (.i_ptr(r_head),      .i_inc(w_n_gnt),  .o_ptr(w_head_nx));
    fl_ptr_inc u_arch    (.i_ptr(r_arch_head), .i_inc(w_n_free), .o_ptr(w_arch_nx));
    fl_ptr_inc u_tail_p1 (.i_ptr(r_tail),      .i_inc(2'd1),     .o_ptr(w_tail_p1));
    fl_ptr_inc u_tail    (.i_ptr(r_tail),      .i_inc(w_n_free), .o_ptr(w_tail_nx));

    assign fl_if.alloc_gnt_0 = w_gnt_0;
    assign fl_if.alloc_gnt_1 = w_gnt_1;
    assign fl_if.alloc_tag_0 = r_entry[r_head];
    assign fl_if.alloc_tag_1 = fl_if.alloc_req_0 ? r_entry[w_head_p1] : r_entry[r_head];
    assign fl_if.free_count = r_count;

    // Flush snaps the spec head onto the arch head, reclaiming every squashed allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= tag_t'(N_ARCH + i);
            r_head <= '0;
            r_arch_head <= '0;
            r_tail <= '0;
            r_count <= cnt_t'(DEPTH);
        end else begin
            if (fl_if.retire_valid_0) r_entry[r_tail] <= fl_if.free_tag_0;
            if (fl_if.retire_valid_1) r_entry[fl_if.retire_valid_0 ? w_tail_p1 : r_tail] <= fl_if.free_tag_1;
            r_head <= fl_if.flush ? w_arch_nx : w_head_nx;
            r_arch_head <= w_arch_nx;
            r_tail <= w_tail_nx;
            r_count <= fl_if.flush ? cnt_t'(DEPTH) : cnt_t'(w_count_nx);
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic r_err;
    logic r_epoch;
    logic w_bad_0;
    logic w_bad_1;
    logic w_err;
    // Until the first grant no tag has been renamed, so an architectural tag cannot legally come back.
    assign w_bad_0 = fl_if.retire_valid_0 && ((r_epoch && fl_if.free_tag_0 < tag_t'(N_ARCH)) || fl_if.free_tag_0 >= tag_t'(N_PRF));
    assign w_bad_1 = fl_if.retire_valid_1 && ((r_epoch && fl_if.free_tag_1 < tag_t'(N_ARCH)) || fl_if.free_tag_1 >= tag_t'(N_PRF));
    assign w_err = w_bad_0 || w_bad_1
                || (fl_if.retire_valid_0 && fl_if.retire_valid_1 && fl_if.free_tag_0 == fl_if.free_tag_1)
                || (!fl_if.flush && w_count_nx > (CNT_W+1)'(DEPTH));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_epoch <= 1'b1;
        end else begin
            r_err <= r_err || w_err;
            r_epoch <= r_epoch && !(w_gnt_0 || w_gnt_1);
        end
    end
    assign fl_if.free_list_err = r_err;
`else
    assign fl_if.free_list_err = 1'b0;
`endif
endmodule

// File: tb/tb_prf_free_list.sv
// tb_prf_free_list: directed self-checking bench for prf_free_list (FREE_LIST_CHECK_EN selects the error test).
module tb_prf_free_list;
    import prf_free_list_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    prf_free_list_if fl_if();
    prf_free_list dut (.clk(clk), .rst_n(rst_n), .fl_if(fl_if));

    always #5 clk = ~clk;

    task automatic idle();
        fl_if.alloc_req_0 = 1'b0;
        fl_if.alloc_req_1 = 1'b0;
        fl_if.retire_valid_0 = 1'b0;
        fl_if.retire_valid_1 = 1'b0;
        fl_if.free_tag_0 = '0;
        fl_if.free_tag_1 = '0;
        fl_if.flush = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        fl_if.alloc_req_0 = 1'b1;
        fl_if.alloc_req_1 = 1'b1;
        #1;
        checks += 6;
        if (fl_if.alloc_gnt_0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", fl_if.alloc_gnt_0); end
        if (fl_if.alloc_gnt_1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b exp=0", fl_if.alloc_gnt_1); end
        if (fl_if.alloc_tag_0 !== tag_t'(32)) begin failures++; $display("FAIL reset_tag0 got=%0d exp=32", fl_if.alloc_tag_0); end
        if (fl_if.alloc_tag_1 !== tag_t'(33)) begin failures++; $display("FAIL reset_tag1 got=%0d exp=33", fl_if.alloc_tag_1); end
        if (fl_if.free_count !== cnt_t'(33)) begin failures++; $display("FAIL reset_count got=%0d exp=33", fl_if.free_count); end
        if (fl_if.free_list_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", fl_if.free_list_err); end
        repeat (2) @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_drain();
        for (int c = 0; c < 17; c++) begin
            fl_if.alloc_req_0 = 1'b1;
            fl_if.alloc_req_1 = 1'b1;
            #1;
            checks += 4;
            if (fl_if.free_count !== cnt_t'(33 - 2*c)) begin failures++; $display("FAIL drain_count c=%0d got=%0d exp=%0d", c, fl_if.free_count, 33 - 2*c); end
            if (fl_if.alloc_gnt_0 !== 1'b1 || fl_if.alloc_tag_0 !== tag_t'(32 + 2*c)) begin
                failures++; $display("FAIL drain_slot0 c=%0d got=%b/%0d exp=1/%0d", c, fl_if.alloc_gnt_0, fl_if.alloc_tag_0, 32 + 2*c);
            end
            if (fl_if.alloc_gnt_1 !== (c < 16)) begin failures++; $display("FAIL drain_gnt1 c=%0d got=%b exp=%b", c, fl_if.alloc_gnt_1, c < 16); end
            if (c < 16 && fl_if.alloc_tag_1 !== tag_t'(33 + 2*c)) begin failures++; $display("FAIL drain_tag1 c=%0d got=%0d exp=%0d", c, fl_if.alloc_tag_1, 33 + 2*c); end
            @(negedge clk);
        end
        #1;
        checks += 2;
        if (fl_if.free_count !== cnt_t'(0)) begin failures++; $display("FAIL drain_empty_count got=%0d exp=0", fl_if.free_count); end
        if (fl_if.alloc_gnt_0 !== 1'b0) begin failures++; $display("FAIL drain_empty_gnt0 got=%b exp=0", fl_if.alloc_gnt_0); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_empty_free();
        fl_if.alloc_req_0 = 1'b1;
        fl_if.retire_valid_0 = 1'b1;
        fl_if.free_tag_0 = tag_t'(5);
        #1;
        checks++;
        if (fl_if.alloc_gnt_0 !== 1'b0) begin failures++; $display("FAIL empty_nobypass_gnt0 got=%b exp=0", fl_if.alloc_gnt_0); end
        @(negedge clk);
        fl_if.retire_valid_0 = 1'b0;
        #1;
        checks += 3;
        if (fl_if.free_count !== cnt_t'(1)) begin failures++; $display("FAIL empty_refill_count got=%0d exp=1", fl_if.free_count); end
        if (fl_if.alloc_gnt_0 !== 1'b1) begin failures++; $display("FAIL empty_refill_gnt0 got=%b exp=1", fl_if.alloc_gnt_0); end
        if (fl_if.alloc_tag_0 !== tag_t'(5)) begin failures++; $display("FAIL empty_refill_tag0 got=%0d exp=5", fl_if.alloc_tag_0); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (fl_if.free_count !== cnt_t'(0)) begin failures++; $display("FAIL empty_after_count got=%0d exp=0", fl_if.free_count); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            fl_if.alloc_req_0 = 1'b1;
            fl_if.alloc_req_1 = 1'b1;
            #1;
            checks++;
            if (fl_if.alloc_tag_0 !== tag_t'(32 + 2*c) || fl_if.alloc_tag_1 !== tag_t'(33 + 2*c)) begin
                failures++; $display("FAIL flush_alloc c=%0d got=%0d,%0d exp=%0d,%0d", c, fl_if.alloc_tag_0, fl_if.alloc_tag_1, 32 + 2*c, 33 + 2*c);
            end
            @(negedge clk);
        end
        idle();
        fl_if.retire_valid_0 = 1'b1;
        fl_if.free_tag_0 = tag_t'(7);
        #1;
        checks++;
        if (fl_if.free_count !== cnt_t'(29)) begin failures++; $display("FAIL flush_pre_count got=%0d exp=29", fl_if.free_count); end
        @(negedge clk);
        idle();
        fl_if.flush = 1'b1;
        fl_if.alloc_req_0 = 1'b1;
        #1;
        checks += 2;
        if (fl_if.alloc_gnt_0 !== 1'b0) begin failures++; $display("FAIL flush_gnt_forced got=%b exp=0", fl_if.alloc_gnt_0); end
        if (fl_if.free_count !== cnt_t'(30)) begin failures++; $display("FAIL flush_retire_count got=%0d exp=30", fl_if.free_count); end
        @(negedge clk);
        idle();
        fl_if.alloc_req_1 = 1'b1;
        #1;
        checks += 3;
        if (fl_if.free_count !== cnt_t'(33)) begin failures++; $display("FAIL flush_restore_count got=%0d exp=33", fl_if.free_count); end
        if (fl_if.alloc_gnt_1 !== 1'b1) begin failures++; $display("FAIL flush_slot1_only_gnt got=%b exp=1", fl_if.alloc_gnt_1); end
        if (fl_if.alloc_tag_1 !== tag_t'(33)) begin failures++; $display("FAIL flush_slot1_only_tag got=%0d exp=33", fl_if.alloc_tag_1); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (fl_if.free_count !== cnt_t'(32)) begin failures++; $display("FAIL flush_post_count got=%0d exp=32", fl_if.free_count); end
    endtask

    task automatic test_wrap();
        int exp_tag;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            fl_if.alloc_req_0 = 1'b1;
            fl_if.retire_valid_0 = 1'b1;
            fl_if.free_tag_0 = tag_t'(k);
            exp_tag = (k < 33) ? 32 + k : k - 33;
            #1;
            checks += 2;
            if (fl_if.alloc_gnt_0 !== 1'b1 || fl_if.alloc_tag_0 !== tag_t'(exp_tag)) begin
                failures++; $display("FAIL wrap_tag k=%0d got=%b/%0d exp=1/%0d", k, fl_if.alloc_gnt_0, fl_if.alloc_tag_0, exp_tag);
            end
            if (fl_if.free_count !== cnt_t'(33)) begin failures++; $display("FAIL wrap_count k=%0d got=%0d exp=33", k, fl_if.free_count); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        fl_if.alloc_req_0 = 1'b1;
        fl_if.alloc_req_1 = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (fl_if.alloc_tag_0 !== tag_t'(42) || fl_if.free_count !== cnt_t'(23)) begin
            failures++; $display("FAIL async_pre got=%0d/%0d exp=42/23", fl_if.alloc_tag_0, fl_if.free_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (fl_if.alloc_tag_0 !== tag_t'(32) || fl_if.alloc_tag_1 !== tag_t'(33)) begin
            failures++; $display("FAIL async_tags got=%0d,%0d exp=32,33", fl_if.alloc_tag_0, fl_if.alloc_tag_1);
        end
        if (fl_if.free_count !== cnt_t'(33)) begin failures++; $display("FAIL async_count got=%0d exp=33", fl_if.free_count); end
        if (fl_if.alloc_gnt_0 !== 1'b0) begin failures++; $display("FAIL async_gnt0 got=%b exp=0", fl_if.alloc_gnt_0); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_err_flag();
        apply_reset();
        fl_if.alloc_req_0 = 1'b1;
        @(negedge clk);
        idle();
        fl_if.retire_valid_0 = 1'b1;
        fl_if.retire_valid_1 = 1'b1;
        fl_if.free_tag_0 = tag_t'(12);
        fl_if.free_tag_1 = tag_t'(12);
        #1;
        checks++;
        if (fl_if.free_list_err !== 1'b0) begin failures++; $display("FAIL err_before_edge got=%b exp=0", fl_if.free_list_err); end
        @(negedge clk);
        idle();
`ifdef FREE_LIST_CHECK_EN
        #1;
        checks++;
        if (fl_if.free_list_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", fl_if.free_list_err); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (fl_if.free_list_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", fl_if.free_list_err); end
        apply_reset();
        #1;
        checks++;
        if (fl_if.free_list_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", fl_if.free_list_err); end
`else
        #1;
        checks++;
        if (fl_if.free_list_err !== 1'b0) begin failures++; $display("FAIL err_tied_off got=%b exp=0", fl_if.free_list_err); end
`endif
        @(negedge clk);
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_drain();
        test_empty_free();
        test_flush();
        test_wrap();
        test_async_reset();
        test_err_flag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
